// File: rtl/lpm_fifo2.sv
// Single-clock FIFO with non-power-of-2 depth, normal or show-ahead read, sticky error flags.
// Status flags come only from the registered occupancy count.
module lpm_fifo2 #(
  parameter int unsigned lpm_width          = 8,
  parameter int unsigned lpm_widthu         = 3,
  parameter int unsigned lpm_numwords       = 5,
  parameter int unsigned lpm_showahead      = 0,
  parameter int unsigned allow_rw_when_full = 0,
  parameter int unsigned almost_full_level  = 4,
  parameter int unsigned almost_empty_level = 1
) (
  input  logic                  clock,
  input  logic                  sclr_n,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic [lpm_widthu:0]   usedw,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [lpm_widthu-1:0] LastIdx  = lpm_widthu'(lpm_numwords - 1);
  localparam logic [lpm_widthu:0]   NumWords = (lpm_widthu + 1)'(lpm_numwords);

  logic [lpm_width-1:0]  mem [lpm_numwords];
  logic [lpm_widthu-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [lpm_widthu:0]   usedw_q, usedw_d;
  logic [lpm_width-1:0]  q_q, q_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_ok, rd_ok;
  logic [31:0]           usedw_ext;

  function automatic logic [lpm_widthu-1:0] ptr_inc(input logic [lpm_widthu-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  assign full         = (usedw_q == NumWords);
  assign empty        = (usedw_q == '0);
  assign usedw_ext    = 32'(usedw_q);
  assign almost_full  = (usedw_ext >= almost_full_level);
  assign almost_empty = (usedw_ext <= almost_empty_level);

  assign wr_ok = wrreq & (~full | ((allow_rw_when_full != 0) & rdreq));
  assign rd_ok = rdreq & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    usedw_d     = usedw_q;
    if (wr_ok && !rd_ok) usedw_d = usedw_q + 1'b1;
    if (rd_ok && !wr_ok) usedw_d = usedw_q - 1'b1;
    overflow_d  = overflow_q | (wrreq & ~wr_ok);
    underflow_d = underflow_q | (rdreq & empty);
  end

  // Show-ahead: q tracks the post-edge head; forward data when the head is the slot being written.
  always_comb begin
    q_d = q_q;
    if (lpm_showahead == 0) begin
      if (rd_ok) q_d = mem[rd_ptr_q];
    end else if (usedw_d != '0) begin
      q_d = (wr_ok && (wr_ptr_q == rd_ptr_d)) ? data : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_q] <= data;
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      q_q         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      q_q         <= q_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign q         = q_q;
  assign usedw     = usedw_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lpm_fifo2.sv
// Drives a normal-mode FIFO and a show-ahead/allow_rw_when_full FIFO with shared stimulus,
// each compared against a queue-based reference model.
module tb_lpm_fifo2;

  logic       clock = 1'b0;
  logic       sclr_n, wrreq, rdreq;
  logic [7:0] data;

  logic [7:0] q_v     [2];
  logic [3:0] uw_v    [2];
  logic       full_v  [2];
  logic       empty_v [2];
  logic       af_v    [2];
  logic       ae_v    [2];
  logic       ovf_v   [2];
  logic       udf_v   [2];

  int n_total = 0;
  int n_bad   = 0;

  // Reference: index 0 = normal mode, allow_rw_when_full=0; index 1 = show-ahead, allow=1.
  logic [7:0] mq  [2][$];
  logic [7:0] mqo [2];
  bit         movf[2];
  bit         mudf[2];

  lpm_fifo2 u_norm (
    .clock(clock), .sclr_n(sclr_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_v[0]), .usedw(uw_v[0]), .full(full_v[0]), .empty(empty_v[0]),
    .almost_full(af_v[0]), .almost_empty(ae_v[0]), .overflow(ovf_v[0]), .underflow(udf_v[0])
  );

  lpm_fifo2 #(
    .lpm_showahead(1),
    .allow_rw_when_full(1)
  ) u_sa (
    .clock(clock), .sclr_n(sclr_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_v[1]), .usedw(uw_v[1]), .full(full_v[1]), .empty(empty_v[1]),
    .almost_full(af_v[1]), .almost_empty(ae_v[1]), .overflow(ovf_v[1]), .underflow(udf_v[1])
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit w, input bit r, input logic [7:0] d, input bit rst);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        mqo[k]  = 8'h00;
        movf[k] = 1'b0;
        mudf[k] = 1'b0;
      end else begin
        bit is_full, is_empty, wr_ok, rd_ok;
        is_full  = (mq[k].size() == 5);
        is_empty = (mq[k].size() == 0);
        wr_ok    = w && (!is_full || (k == 1 && r));
        rd_ok    = r && !is_empty;
        if (w && !wr_ok) movf[k] = 1'b1;
        if (r && is_empty) mudf[k] = 1'b1;
        if (rd_ok) begin
          if (k == 0) mqo[k] = mq[k][0];
          void'(mq[k].pop_front());
        end
        if (wr_ok) mq[k].push_back(d);
        if (k == 1 && mq[k].size() > 0) mqo[k] = mq[k][0];
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = mq[k].size();
      check($sformatf("u%0d.usedw", k), 32'(uw_v[k]), 32'(sz));
      check($sformatf("u%0d.q", k), 32'(q_v[k]), 32'(mqo[k]));
      check($sformatf("u%0d.flags{full,empty,af,ae,ovf,udf}", k),
            32'({full_v[k], empty_v[k], af_v[k], ae_v[k], ovf_v[k], udf_v[k]}),
            32'({sz == 5, sz == 0, sz >= 4, sz <= 1, movf[k], mudf[k]}));
    end
  endtask

  task automatic cycle(input bit w, input bit r, input logic [7:0] d, input bit rst);
    wrreq  = w;
    rdreq  = r;
    data   = d;
    sclr_n = ~rst;
    @(posedge clock);
    model_step(w, r, d, rst);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    sclr_n = 1'b0;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    data   = 8'h00;

    cycle(1'b1, 1'b1, 8'h77, 1'b1);

    // Fill 0x11..0x15 then drain.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Overflow on full, underflow on empty.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 8'hEE, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Pointer wrap at non-power-of-2 depth.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Show-ahead head visibility and forwarding with one word left.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h5A, 1'b0);
    cycle(1'b1, 1'b1, 8'h5B, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Read+write while full.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(8'hD0 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Reset mid-stream with requests asserted; first post-reset write comes out first.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hBF, 1'b1);
    cycle(1'b1, 1'b0, 8'hE1, 1'b0);
    cycle(1'b1, 1'b0, 8'hE2, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Random traffic with phase-varying bias and occasional reset.
    for (int i = 0; i < 800; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 70 : 35;
      cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 50,
            8'($urandom_range(0, 255)), $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lpm_fifo2.md
LPM_FIFO2 -- requirements
Module: lpm_fifo2

Interface
REQ-001 SHALL provide these parameters, one per line as name, default, meaning:
- lpm_width, 8, data word width in bits (>=1).
- lpm_widthu, 3, pointer width in bits.
- lpm_numwords, 5, storage depth; 2 <= lpm_numwords <= 2^lpm_widthu; non-power-of-2 values supported.
- lpm_showahead, 0, 0 = normal read mode, 1 = show-ahead mode.
- allow_rw_when_full, 0, 1 = a write is accepted when full if a read occurs in the same cycle.
- almost_full_level, 4, almost_full threshold in words.
- almost_empty_level, 1, almost_empty threshold in words.
REQ-002 SHALL provide these ports, one per line as name, direction, width, meaning:
- clock, in, 1, sole clock; all state changes on the rising edge.
- sclr_n, in, 1, reset; one clock, and the reset is synchronous and active-low.
- data, in, lpm_width, write data.
- wrreq, in, 1, write request.
- rdreq, in, 1, read request (normal mode) or acknowledge of the head word (show-ahead mode).
- q, out, lpm_width, read data.
- usedw, out, lpm_widthu+1, occupancy, 0..lpm_numwords.
- full, out, 1, usedw == lpm_numwords.
- empty, out, 1, usedw == 0.
- almost_full, out, 1, usedw >= almost_full_level.
- almost_empty, out, 1, usedw <= almost_empty_level.
- overflow, out, 1, sticky: a write was refused.
- underflow, out, 1, sticky: a read was refused.

Function
REQ-003 Accepted write (wr_ok) SHALL be: wrreq and (not full, or (allow_rw_when_full and rdreq)).
REQ-004 Accepted read (rd_ok) SHALL be: rdreq and not empty; a read never completes against data written in the same cycle.
REQ-005 On wr_ok, data SHALL be stored at wr_ptr, and wr_ptr SHALL advance, wrapping from lpm_numwords-1 to 0.
REQ-006 On rd_ok, rd_ptr SHALL advance with the same wrap rule.
REQ-007 usedw SHALL be registered and update on the same clock edge:
- +1 on wr_ok only.
- -1 on rd_ok only.
- unchanged when both or neither occur.
REQ-008 full, empty, almost_full and almost_empty SHALL be derived only from the registered usedw, with no combinational path from wrreq or rdreq.
REQ-009 In normal mode (lpm_showahead=0):
- On rd_ok, q SHALL present the word at the old rd_ptr after the same edge, i.e. read latency 1.
- q SHALL otherwise hold its value.
REQ-010 In show-ahead mode (lpm_showahead=1), q SHALL be a register tracking the head word:
- The head word is visible on the same edge that empty falls, i.e. write-to-q latency 1 from an empty FIFO.
- After rd_ok, the next word is visible on the same edge, or q holds if the FIFO becomes empty.
- A simultaneous write when one word remains SHALL forward the written data to q.
REQ-011 overflow SHALL set on any cycle with wrreq and not wr_ok; underflow SHALL set on any cycle with rdreq and empty; both SHALL stay set until reset.
REQ-012 Simultaneous wr_ok and rd_ok while full (allow_rw_when_full=1) SHALL leave usedw = lpm_numwords and full = 1, and SHALL NOT set overflow.
REQ-013 The implementation SHALL use at most lpm_numwords storage words and no latch or negative-edge logic.

Reset
REQ-014 When sclr_n=0 at a rising edge, the block SHALL reset regardless of wrreq and rdreq, with this result:
- pointers = 0, usedw = 0, empty = 1, full = 0.
- almost_empty = 1, almost_full = (almost_full_level == 0).
- overflow = 0, underflow = 0, q = 0.
- Storage contents need not be cleared.
REQ-015 Reset asserted mid-stream SHALL discard all stored words; the first write after release SHALL be read back first.

Verification (lpm_width=8, lpm_numwords=5, lpm_widthu=3, almost_full_level=4, almost_empty_level=1 unless noted)
REQ-016 Normal mode, write 0x11..0x15 over 5 cycles -> usedw steps 1..5; almost_empty falls at usedw=2; almost_full rises at usedw=4; full=1 at usedw=5. Then 5 reads -> q = 0x11..0x15, each one cycle after its rdreq, and empty=1 after the last read.
REQ-017 Full FIFO with wrreq=1, rdreq=0 -> usedw stays 5, data is unchanged, overflow=1 from the next cycle and stays set. Empty FIFO with rdreq=1 -> underflow=1 and usedw stays 0.
REQ-018 Wrap-around: 3 writes, 3 reads, then 5 writes 0xA0..0xA4 and 5 reads -> q = 0xA0..0xA4 in order, confirming non-power-of-2 pointer wrap.
REQ-019 Show-ahead mode, write 0x5A into an empty FIFO -> next cycle empty=0 and q=0x5A with no rdreq. Then write 0x5B and issue rdreq -> q=0x5B after that edge.
REQ-020 allow_rw_when_full=1, full FIFO, wrreq=rdreq=1 for 3 cycles -> usedw=5 and full=1 throughout, overflow=0, and the read-out order is preserved. With sclr_n=0 pulsed while usedw=3 -> next cycle usedw=0, empty=1, q=0, and both sticky flags are 0.
